// File: rtl/gba_sound_dma_fifo.sv
// -----------------------------------------------------------------------------
// gba_sound_dma_fifo
//
// Direct Sound sample FIFO for one GBA Direct Sound channel (A or B).
//
// Each CPU or DMA write to the FIFO register pushes the enabled byte lanes,
// lowest lane first. Each overflow tick from the selected timer pops one
// signed 8-bit sample to the mixer. When the level left after a pop is at or
// below REQ_LEVEL, the block pulses a refill request to the sound DMA
// channel.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high reset
//   gb_on        core enable; when low, all state is frozen
//   fifo_wr      one-cycle write strobe for this channel's FIFO register
//   fifo_din     write data; byte lane n is bits [8n+7:8n]
//   fifo_be      byte enables qualifying fifo_wr
//   fifo_clear   one-cycle FIFO reset pulse from SOUNDCNT_H
//   timer_sel    pop timer select: 0 = timer0, 1 = timer1
//   timer0_tick  overflow pulse from timer0
//   timer1_tick  overflow pulse from timer1
//   sample_out   current signed sample (registered)
//   sample_valid one-cycle pulse when sample_out is updated by a pop
//   dma_req      one-cycle refill request pulse
//   fill_level   number of bytes stored, 0..32
//   debugout     {8'h00, rd_ptr, 3'b0, wr_ptr, 3'b0, 2'b0, fill_level}
// -----------------------------------------------------------------------------
module gba_sound_dma_fifo #(
    parameter int DEPTH_BYTES = 32,
    parameter int REQ_LEVEL   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        gb_on,
    input  logic        fifo_wr,
    input  logic [31:0] fifo_din,
    input  logic [3:0]  fifo_be,
    input  logic        fifo_clear,
    input  logic        timer_sel,
    input  logic        timer0_tick,
    input  logic        timer1_tick,
    output logic [7:0]  sample_out,
    output logic        sample_valid,
    output logic        dma_req,
    output logic [5:0]  fill_level,
    output logic [31:0] debugout
);

    localparam int AW = $clog2(DEPTH_BYTES);
    localparam int CW = AW + 1;

    logic [7:0]    mem_q [DEPTH_BYTES];
    logic [7:0]    mem_d [DEPTH_BYTES];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    sample_out_q, sample_out_d;
    logic          sample_valid_q, sample_valid_d;
    logic          dma_req_q, dma_req_d;

    logic          tick_s;
    logic [CW-1:0] popped_s;
    logic [CW-1:0] level_after_pop_s;
    logic [CW-1:0] accepted_s;

    assign tick_s = timer_sel ? timer1_tick : timer0_tick;

    // Next-state logic: reset, then enable gate, then clear, then push/pop.
    always_comb begin
        mem_d             = mem_q;
        wr_ptr_d          = wr_ptr_q;
        rd_ptr_d          = rd_ptr_q;
        count_d           = count_q;
        sample_out_d      = sample_out_q;
        sample_valid_d    = 1'b0;
        dma_req_d         = 1'b0;
        popped_s          = {CW{1'b0}};
        level_after_pop_s = count_q;
        accepted_s        = {CW{1'b0}};

        if (reset) begin
            wr_ptr_d     = {AW{1'b0}};
            rd_ptr_d     = {AW{1'b0}};
            count_d      = {CW{1'b0}};
            sample_out_d = 8'h00;
        end else if (!gb_on) begin
            // Frozen: hold everything, pulses stay low.
            count_d = count_q;
        end else if (fifo_clear) begin
            wr_ptr_d     = {AW{1'b0}};
            rd_ptr_d     = {AW{1'b0}};
            count_d      = {CW{1'b0}};
            sample_out_d = 8'h00;
        end else begin
            // The pop uses the pre-cycle count and the old head, so a byte
            // written into an empty FIFO this cycle cannot also be popped.
            if (tick_s && (count_q != {CW{1'b0}})) begin
                popped_s       = CW'(1);
                sample_out_d   = mem_q[rd_ptr_q];
                rd_ptr_d       = rd_ptr_q + AW'(1);
                sample_valid_d = 1'b1;
            end else begin
                popped_s = {CW{1'b0}};
            end

            level_after_pop_s = count_q - popped_s;

            // Lanes go in ascending order; the space check includes this
            // cycle's pop, so a full FIFO popped and written takes 1 byte.
            if (fifo_wr) begin
                for (int n = 0; n < 4; n++) begin
                    if (fifo_be[n] &&
                        ((level_after_pop_s + accepted_s) < CW'(DEPTH_BYTES))) begin
                        mem_d[wr_ptr_q + accepted_s[AW-1:0]] = fifo_din[8*n +: 8];
                        accepted_s = accepted_s + CW'(1);
                    end else begin
                        accepted_s = accepted_s;
                    end
                end
            end else begin
                accepted_s = {CW{1'b0}};
            end

            wr_ptr_d  = wr_ptr_q + accepted_s[AW-1:0];
            count_d   = level_after_pop_s + accepted_s;
            // Requests also fire on ticks that find the FIFO empty.
            dma_req_d = tick_s && (level_after_pop_s <= CW'(REQ_LEVEL));
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        mem_q          <= mem_d;
        wr_ptr_q       <= wr_ptr_d;
        rd_ptr_q       <= rd_ptr_d;
        count_q        <= count_d;
        sample_out_q   <= sample_out_d;
        sample_valid_q <= sample_valid_d;
        dma_req_q      <= dma_req_d;
    end

    assign sample_out   = sample_out_q;
    assign sample_valid = sample_valid_q;
    assign dma_req      = dma_req_q;
    assign fill_level   = 6'(count_q);
    assign debugout     = {8'h00, 5'(rd_ptr_q), 3'b000, 5'(wr_ptr_q), 3'b000,
                           2'b00, 6'(count_q)};

endmodule

// File: tb/tb_gba_sound_dma_fifo.sv
module tb_gba_sound_dma_fifo;

    logic        clk = 1'b0;
    logic        reset, gb_on, fifo_wr, fifo_clear, timer_sel, timer0_tick, timer1_tick;
    logic [31:0] fifo_din;
    logic [3:0]  fifo_be;
    logic [7:0]  sample_out;
    logic        sample_valid, dma_req;
    logic [5:0]  fill_level;
    logic [31:0] debugout;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: a byte queue plus free-running pointer counters.
    byte unsigned q[$];
    int           m_wr = 0, m_rd = 0;
    logic [7:0]   m_sample = 8'h00;
    logic         m_valid = 1'b0, m_req = 1'b0;

    gba_sound_dma_fifo dut (
        .clk(clk), .reset(reset), .gb_on(gb_on), .fifo_wr(fifo_wr),
        .fifo_din(fifo_din), .fifo_be(fifo_be), .fifo_clear(fifo_clear),
        .timer_sel(timer_sel), .timer0_tick(timer0_tick), .timer1_tick(timer1_tick),
        .sample_out(sample_out), .sample_valid(sample_valid), .dma_req(dma_req),
        .fill_level(fill_level), .debugout(debugout)
    );

    always #30 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, advance the model, then check all outputs.
    task automatic step(input logic rst, input logic on, input logic wr,
                        input logic [31:0] din, input logic [3:0] be,
                        input logic clr, input logic sel,
                        input logic t0, input logic t1);
        logic tk;
        int   pre;
        reset = rst; gb_on = on; fifo_wr = wr; fifo_din = din; fifo_be = be;
        fifo_clear = clr; timer_sel = sel; timer0_tick = t0; timer1_tick = t1;

        m_valid = 1'b0;
        m_req   = 1'b0;
        if (rst || (on && clr)) begin
            q.delete();
            m_wr = 0; m_rd = 0; m_sample = 8'h00;
        end else if (on) begin
            tk  = sel ? t1 : t0;
            pre = q.size();
            if (tk && pre > 0) begin
                m_sample = q.pop_front();
                m_rd     = (m_rd + 1) % 32;
                m_valid  = 1'b1;
            end
            if (tk) m_req = (q.size() <= 16);
            if (wr) begin
                for (int n = 0; n < 4; n++) begin
                    if (be[n] && q.size() < 32) begin
                        q.push_back(din[8*n +: 8]);
                        m_wr = (m_wr + 1) % 32;
                    end
                end
            end
        end

        @(posedge clk);
        #1;
        chk("fill_level",   {26'd0, fill_level}, q.size());
        chk("sample_out",   {24'd0, sample_out}, {24'd0, m_sample});
        chk("sample_valid", {31'd0, sample_valid}, {31'd0, m_valid});
        chk("dma_req",      {31'd0, dma_req}, {31'd0, m_req});
        chk("debugout", debugout,
            {8'h00, 5'(m_rd), 3'b000, 5'(m_wr), 3'b000, 2'b00, 6'(q.size())});
    endtask

    task automatic wr_word(input logic [31:0] d, input logic [3:0] be);
        step(1'b0, 1'b1, 1'b1, d, be, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick0();
        step(1'b0, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        logic [3:0] rbe;
        logic       rsel, rt0, rt1, rwr, ron, rclr, rrst;

        step(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Ordering, plus an unselected timer1 tick.
        wr_word(32'h04030201, 4'hF);
        for (int i = 0; i < 4; i++) tick0();
        step(1'b0, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Partial lanes.
        wr_word(32'hDDCCBBAA, 4'hC);
        wr_word(32'hDDCCBBAA, 4'h1);
        for (int i = 0; i < 3; i++) tick0();

        // Reset mid-fill at 12 bytes, then a tick on the empty FIFO.
        for (int i = 0; i < 3; i++) wr_word(32'h11223344, 4'hF);
        step(1'b1, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick0();

        // Full, overflow, and write in the same cycle as a tick.
        for (int i = 0; i < 8; i++)
            wr_word({8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)}, 4'hF);
        wr_word(32'hFFFFFFFF, 4'hF);
        step(1'b0, 1'b1, 1'b1, 32'hEEEEEEEE, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0);

        // Threshold: drain past 16 and keep ticking while empty.
        for (int i = 0; i < 36; i++) tick0();

        // Clear priority at level 20.
        for (int i = 0; i < 5; i++) wr_word(32'h55667788, 4'hF);
        step(1'b0, 1'b1, 1'b1, 32'h99999999, 4'hF, 1'b1, 1'b0, 1'b1, 1'b0);

        // gb_on low freezes state.
        wr_word(32'hA1A2A3A4, 4'hF);
        step(1'b0, 1'b0, 1'b1, 32'h12345678, 4'hF, 1'b1, 1'b0, 1'b1, 1'b0);

        // Randomized traffic with alternating write-heavy and tick-heavy phases.
        for (int i = 0; i < 3000; i++) begin
            int ph;
            ph   = (i / 100) % 2;
            rrst = ($urandom_range(0, 499) == 0);
            ron  = ($urandom_range(0, 19) != 0);
            rclr = ($urandom_range(0, 199) == 0);
            rwr  = ($urandom_range(0, 9) < (ph ? 2 : 6));
            rbe  = 4'($urandom);
            rsel = ($urandom_range(0, 99) < 10) ? ~timer_sel : timer_sel;
            rt0  = ($urandom_range(0, 9) < (ph ? 7 : 3));
            rt1  = ($urandom_range(0, 9) < (ph ? 7 : 3));
            step(rrst, ron, rwr, $urandom, rbe, rclr, rsel, rt0, rt1);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
